// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   uart_state_t    : receiver FSM state encoding (IDLE, DATA, PARITY, STOP)
//   UART_DATA_WIDTH : default payload width in bits
//   UART_START_BIT  : line level of the start bit
//   UART_STOP_BIT   : line level of the stop bit
package uart_pkg;

  localparam int   UART_DATA_WIDTH = 32;
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer.
// Frame: start (0), DATA_WIDTH data bits LSB first, optional even parity bit
// (XOR of the data bits), stop (1). One line bit is taken per clk edge where
// Rx_Enable is high; with Rx_Enable low the FSM, counter and shift register
// hold indefinitely.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : PARITY state present, frame is DATA_WIDTH+3 samples
//   undefined : no parity bit, frame is DATA_WIDTH+2 samples,
//               Rx_Parity_Error tied low
//
// Ports
//   clk             : clock, rising edge
//   rst             : asynchronous active-low reset
//   Rx_Enable       : bit-sample strobe
//   Rx_Serial_Input : serial line, idle high
//   Rx_Data         : last correctly received payload
//   Rx_Valid        : one-cycle pulse when Rx_Data is loaded
//   Rx_Parity_Error : one-cycle pulse on parity mismatch (stop bit good)
//   Rx_Frame_Error  : one-cycle pulse on a stop bit of 0
//   Rx_Busy         : high whenever the FSM is outside IDLE
//   fsm_state       : current FSM state, for observation
//
// Pulse outputs: each is high for exactly the one cycle following the edge
// that sampled the stop bit, and clears on the next edge regardless of
// Rx_Enable.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Rx_Enable,
  input  logic                  Rx_Serial_Input,
  output logic [DATA_WIDTH-1:0] Rx_Data,
  output logic                  Rx_Valid,
  output logic                  Rx_Parity_Error,
  output logic                  Rx_Frame_Error,
  output logic                  Rx_Busy,
  output logic [1:0]            fsm_state
);

  // Wide enough to hold DATA_WIDTH itself, so the count never wraps in a frame.
  localparam int CW = $clog2(DATA_WIDTH + 1);

  uart_state_t           state;
  logic [CW-1:0]         bit_count;
  logic [DATA_WIDTH-1:0] shift_reg;

`ifdef UART_RX_PARITY_EN
  logic parity_mismatch;
  logic parity_error_q;
  assign Rx_Parity_Error = parity_error_q;
`else
  assign Rx_Parity_Error = 1'b0;
`endif

  assign Rx_Busy   = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bit_count      <= '0;
      shift_reg      <= '0;
      Rx_Data        <= '0;
      Rx_Valid       <= 1'b0;
      Rx_Frame_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_mismatch <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      // Pulses live for one cycle only, independent of the sample strobe.
      Rx_Valid       <= 1'b0;
      Rx_Frame_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
      if (Rx_Enable) begin
        case (state)
          IDLE: begin
            if (Rx_Serial_Input == UART_START_BIT) begin
              state     <= DATA;
              bit_count <= '0;
            end
          end

          DATA: begin
            // LSB arrives first, so shifting right leaves it in bit 0 at the end.
            shift_reg <= {Rx_Serial_Input, shift_reg[DATA_WIDTH-1:1]};
            bit_count <= bit_count + CW'(1);
            if (bit_count == CW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            parity_mismatch <= Rx_Serial_Input ^ (^shift_reg);
            state           <= STOP;
          end
`endif

          STOP: begin
            // No break detection: whatever the stop bit, the next sample is
            // an IDLE sample, which lets frames run back to back.
            state <= IDLE;
            if (Rx_Serial_Input == UART_STOP_BIT) begin
`ifdef UART_RX_PARITY_EN
              if (parity_mismatch) begin
                parity_error_q <= 1'b1;
              end else begin
                Rx_Data  <= shift_reg;
                Rx_Valid <= 1'b1;
              end
`else
              Rx_Data  <= shift_reg;
              Rx_Valid <= 1'b1;
`endif
            end else begin
              Rx_Frame_Error <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer.
// A reference model builds each frame as a list of line bits, decides the
// outcome from the frame rules (stop bit, even parity) and predicts the cycle
// of the resulting pulse from the frame length plus stalled cycles. A monitor
// logs every observed pulse with its cycle; the scoreboard compares the two.
module tb_uart_rx_deserializer;

  localparam int DW = 32;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FL = DW + 2 + PAR_EN;   // samples per frame
  localparam int EW = 2 + 32 + DW;       // event: {kind, cycle, data}

  localparam logic [1:0] EV_VALID = 2'd1;
  localparam logic [1:0] EV_PERR  = 2'd2;
  localparam logic [1:0] EV_FERR  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          Rx_Enable = 1'b0;
  logic          Rx_Serial_Input = 1'b1;
  logic [DW-1:0] Rx_Data;
  logic          Rx_Valid;
  logic          Rx_Parity_Error;
  logic          Rx_Frame_Error;
  logic          Rx_Busy;
  logic [1:0]    fsm_state;

  uart_rx_deserializer #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .Rx_Enable       (Rx_Enable),
    .Rx_Serial_Input (Rx_Serial_Input),
    .Rx_Data         (Rx_Data),
    .Rx_Valid        (Rx_Valid),
    .Rx_Parity_Error (Rx_Parity_Error),
    .Rx_Frame_Error  (Rx_Frame_Error),
    .Rx_Busy         (Rx_Busy),
    .fsm_state       (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic [DW-1:0] last_good = '0;
  int tests_run = 0;
  int tests_failed = 0;

  function automatic logic [EW-1:0] ev(input logic [1:0] k, input int c,
                                       input logic [DW-1:0] d);
    return {k, 32'(c), d};
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (Rx_Valid)        obs_q.push_back(ev(EV_VALID, cyc, Rx_Data));
      if (Rx_Parity_Error) obs_q.push_back(ev(EV_PERR,  cyc, Rx_Data));
      if (Rx_Frame_Error)  obs_q.push_back(ev(EV_FERR,  cyc, Rx_Data));
    end
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic b);
    @(negedge clk);
    Rx_Enable       = en;
    Rx_Serial_Input = b;
  endtask

  // Sends one frame; stall_len cycles with Rx_Enable=0 (and a random line)
  // are inserted after frame bit stall_pos. The model pushes the expected event.
  task automatic send_frame(input logic [DW-1:0] data, input logic flip_par,
                            input logic stop, input int stall_pos,
                            input int stall_len);
    logic bits[$];
    logic [1:0] kind;
    int t0;
    int delay;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(data[i]);
    if (PAR_EN != 0) bits.push_back((^data) ^ flip_par);
    bits.push_back(stop);
    t0 = 0;
    delay = 0;
    for (int k = 0; k < bits.size(); k++) begin
      drive(1'b1, bits[k]);
      if (k == 0) t0 = cyc;
      if (k == stall_pos && k < FL - 1 && stall_len > 0) begin
        for (int s = 0; s < stall_len; s++) drive(1'b0, 1'($urandom_range(0, 1)));
        delay = stall_len;
      end
    end
    if (stop == 1'b0)                   kind = EV_FERR;
    else if (PAR_EN != 0 && flip_par)   kind = EV_PERR;
    else begin
      kind      = EV_VALID;
      last_good = data;
    end
    exp_q.push_back(ev(kind, t0 + FL + delay, last_good));
  endtask

  // Idle a few samples, then compare observed pulses with the model.
  task automatic check_events(input string tag);
    int n;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    check({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, 128'(obs_q[i]), 128'(exp_q[i]));
    check({tag, "_busy"}, 128'(Rx_Busy), 128'(1'b0));
    check({tag, "_data"}, 128'(Rx_Data), 128'(last_good));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  128'(Rx_Data),         128'(0));
    check({tag, "_valid"}, 128'(Rx_Valid),        128'(0));
    check({tag, "_perr"},  128'(Rx_Parity_Error), 128'(0));
    check({tag, "_ferr"},  128'(Rx_Frame_Error),  128'(0));
    check({tag, "_busy"},  128'(Rx_Busy),         128'(0));
    check({tag, "_state"}, 128'(fsm_state),       128'(uart_pkg::IDLE));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] partial;
    int mode;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Good frame, enable held high
    send_frame(32'hA5A50F0F, 1'b0, 1'b1, -1, 0);
    check_events("good_frame");

    // Bad parity (a correct frame when parity is not built in)
    send_frame(32'h00000001, 1'b1, 1'b1, -1, 0);
    check_events("bad_parity");

    // Bad stop bit
    send_frame(32'h12345678, 1'b0, 1'b0, -1, 0);
    check_events("bad_stop");

    // Back-to-back frames, no idle gap
    send_frame(32'hFFFFFFFF, 1'b0, 1'b1, -1, 0);
    send_frame(32'h00000000, 1'b0, 1'b1, -1, 0);
    check_events("back_to_back");

    // Stalled frame: 10 cycles with Rx_Enable low mid-frame
    send_frame(32'hC3C3_1234, 1'b0, 1'b1, 17, 10);
    check_events("stall");

    // Busy is visible mid-frame
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    @(negedge clk);
    check("busy_mid_frame", 128'(Rx_Busy), 128'(1'b1));

    // Reset after 12 data bits: partial frame discarded, no pulse
    partial = 32'h0000_0ABC;
    rst = 1'b1;
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b1);  // drain the frame above
    obs_q.delete();
    exp_q.delete();
    drive(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, partial[i]);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_frame");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_hold");
    last_good = '0;
    rst = 1'b1;
    send_frame(32'h5A5A_F00D, 1'b0, 1'b1, -1, 0);
    check_events("after_reset");

    // Randomised frames with random gaps, stalls and error injection
    for (int f = 0; f < 12; f++) begin
      d = $urandom;
      mode = $urandom_range(0, 5);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        drive(1'($urandom_range(0, 1)), 1'b1);
      case (mode)
        0:       send_frame(d, 1'b1, 1'b1, -1, 0);
        1:       send_frame(d, 1'($urandom_range(0, 1)), 1'b0, -1, 0);
        2:       send_frame(d, 1'b0, 1'b1, $urandom_range(0, FL - 2),
                            $urandom_range(1, 6));
        default: send_frame(d, 1'b0, 1'b1, -1, 0);
      endcase
      // Occasionally drop the strobe right after the stop bit: the pulse
      // must still clear after one cycle.
      if ($urandom_range(0, 1) == 1) drive(1'b0, 1'b1);
    end
    check_events("random");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
UART_RX_DESERIALIZER -- requirements
Module: uart_rx_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the number of payload bits per frame.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-004 SHALL have port Rx_Enable, input, 1 bit, bit-sample strobe; one line bit sampled per clk edge with Rx_Enable=1.
REQ-005 SHALL have port Rx_Serial_Input, input, 1 bit, serial line; idle high, driven by the UART transmit shifter.
REQ-006 SHALL have port Rx_Data, output, DATA_WIDTH bits, last correctly received payload.
REQ-007 SHALL have port Rx_Valid, output, 1 bit, one-cycle pulse when Rx_Data is updated.
REQ-008 SHALL have port Rx_Parity_Error, output, 1 bit, one-cycle pulse on parity mismatch.
REQ-009 SHALL have port Rx_Frame_Error, output, 1 bit, one-cycle pulse on bad stop bit.
REQ-010 SHALL have port Rx_Busy, output, 1 bit, high in every state except IDLE.

Function
REQ-011 SHALL accept the frame: start bit 0, DATA_WIDTH data bits LSB first, even parity bit (XOR of data bits), stop bit 1.
REQ-012 SHALL implement the FSM states IDLE, DATA, PARITY and STOP.
REQ-013 SHALL, in IDLE, go to DATA on a sampled 0 and clear the bit counter; a sampled 1 keeps it in IDLE.
REQ-014 SHALL, in DATA, shift each sampled bit into the MSB of the shift register (shift right) and increment the counter; after DATA_WIDTH samples it goes to PARITY.
REQ-015 SHALL, in PARITY, compare the sampled bit with the XOR of the shift register, store the mismatch flag, and go to STOP.
REQ-016 SHALL, in STOP, always return to IDLE and act on the sampled bit:
- stop=1 with no parity mismatch: load Rx_Data and pulse Rx_Valid.
- stop=1 with parity mismatch: pulse Rx_Parity_Error; Rx_Data keeps its value.
- stop=0: pulse Rx_Frame_Error regardless of parity; Rx_Data keeps its value.
REQ-017 SHALL assert each pulse for exactly one clk cycle, in the cycle after the edge that sampled the stop bit.
REQ-018 SHALL deassert the pulses on the next edge whether or not Rx_Enable is high.
REQ-019 SHALL give a frame length of DATA_WIDTH+3 sampled bits (35 for the default).
REQ-020 SHALL accept a new start bit on the sample immediately after the stop bit, so back-to-back frames work.
REQ-021 SHALL freeze FSM, counter and shift register while Rx_Enable=0, with no timeout.
REQ-022 SHALL size the bit counter to clog2(DATA_WIDTH+1) bits; it SHALL never wrap within a frame.
REQ-023 SHALL NOT detect break conditions: a stop=0 is only a frame error, and the next sample is treated as IDLE.

Reset
REQ-024 SHALL, while rst=0, force:
- state = IDLE;
- counter, shift register and Rx_Data = 0;
- Rx_Valid, Rx_Parity_Error, Rx_Frame_Error and Rx_Busy = 0.
REQ-025 SHALL discard a partial frame when rst asserts mid-frame, with no error pulse.
REQ-026 SHALL treat the first sample after release as an IDLE sample.

Configuration
REQ-027 SHALL use the macro UART_RX_PARITY_EN.
REQ-028 SHALL, with UART_RX_PARITY_EN defined, include the PARITY state and checking as in REQ-015/016.
REQ-029 SHALL, without it, omit the PARITY state:
- DATA goes directly to STOP;
- the frame is DATA_WIDTH+2 bits;
- Rx_Parity_Error is tied 0.

Structure
REQ-030 SHALL define in shared package uart_pkg:
- the FSM state enum (IDLE, DATA, PARITY, STOP);
- UART_DATA_WIDTH = 32;
- UART_START_BIT = 0 and UART_STOP_BIT = 1.
REQ-031 SHALL be a single flat module with no sub-module.

Verification
REQ-032 SHALL cover a good frame: payload 0xA5A50F0F, parity 0, Rx_Enable held 1 -> Rx_Data=0xA5A50F0F and one-cycle Rx_Valid on the cycle after the 35th sample; both error pulses stay 0.
REQ-033 SHALL cover bad parity: payload 0x00000001 sent with parity 0 -> one Rx_Parity_Error pulse, no Rx_Valid, Rx_Data unchanged.
REQ-034 SHALL cover a bad stop bit: payload 0x12345678 sent with stop=0 -> one Rx_Frame_Error pulse, no Rx_Valid, FSM back in IDLE (Rx_Busy=0).
REQ-035 SHALL cover back-to-back frames: 0xFFFFFFFF then 0x00000000 with no idle gap -> two Rx_Valid pulses 35 cycles apart with the correct data each.
REQ-036 SHALL cover a stalled frame: Rx_Enable=0 for 10 cycles mid-frame -> data correct, Rx_Valid delayed by exactly 10 cycles.
REQ-037 SHALL cover reset mid-frame: rst=0 after 12 data bits -> all outputs 0; a complete frame sent after release is received correctly.
